// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: consumes CHUNK bits per clock, LSB chunk first,
// with a registered carry between chunks and valid/ready handshakes on both sides.
module serial_adder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sub_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] s_o,
  output logic             cout_o,
  output logic             ovf_o
);

  localparam int unsigned N    = WIDTH / CHUNK;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

  if ((WIDTH < 2) || ((WIDTH % CHUNK) != 0)) begin : gen_param_check
    $error("serial_adder: WIDTH must be >= 2 and a multiple of CHUNK");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic              carry_q, carry_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  s_q, s_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;
  logic [CHUNK:0]    chunk_sum;

  assign chunk_sum = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]}
                   + {{CHUNK{1'b0}}, carry_q};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid_i) begin
          state_d = StRun;
          a_d     = a_i;
          b_d     = b_i ^ {WIDTH{sub_i}};
          carry_d = sub_i;
          cnt_d   = '0;
          acc_d   = '0;
        end
      end
      StRun: begin
        // Operands shift right so the active chunk always sits in the low bits;
        // result chunks enter the accumulator from the top.
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        carry_d = chunk_sum[CHUNK];
        acc_d   = (acc_q >> CHUNK) | (WIDTH'(chunk_sum[CHUNK-1:0]) << (WIDTH - CHUNK));
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == CntW'(N - 1)) begin
          state_d = StDone;
          s_d     = acc_d;
          cout_d  = chunk_sum[CHUNK];
          // On the last chunk the low bits hold the original operand MSBs.
          ovf_d   = (a_q[CHUNK-1] == b_q[CHUNK-1]) && (acc_d[WIDTH-1] != a_q[CHUNK-1]);
        end
      end
      StDone: begin
        if (out_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready_o  = (state_q == StIdle);
  assign out_valid_o = (state_q == StDone);
  assign s_o         = s_q;
  assign cout_o      = cout_q;
  assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (8/2) plus randomised back-to-back runs on
// 16/16 and 16/1 instances checked against a full-width arithmetic model.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       in_valid, in_ready, sub, out_valid, out_ready, cout, ovf;
  logic [7:0] a, b, s;

  logic        w_in_valid[2], w_in_ready[2], w_sub[2], w_out_valid[2], w_out_ready[2];
  logic        w_cout[2], w_ovf[2];
  logic [15:0] w_a[2], w_b[2], w_s[2];

  int errors = 0;
  int checks = 0;

  serial_adder #(.WIDTH(8), .CHUNK(2)) u_dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .a_i(a), .b_i(b), .sub_i(sub), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .s_o(s), .cout_o(cout), .ovf_o(ovf)
  );

  serial_adder #(.WIDTH(16), .CHUNK(16)) u_dut_w16 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(w_in_valid[0]), .in_ready_o(w_in_ready[0]),
    .a_i(w_a[0]), .b_i(w_b[0]), .sub_i(w_sub[0]), .out_valid_o(w_out_valid[0]),
    .out_ready_i(w_out_ready[0]), .s_o(w_s[0]), .cout_o(w_cout[0]), .ovf_o(w_ovf[0])
  );

  serial_adder #(.WIDTH(16), .CHUNK(1)) u_dut_w1 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(w_in_valid[1]), .in_ready_o(w_in_ready[1]),
    .a_i(w_a[1]), .b_i(w_b[1]), .sub_i(w_sub[1]), .out_valid_o(w_out_valid[1]),
    .out_ready_i(w_out_ready[1]), .s_o(w_s[1]), .cout_o(w_cout[1]), .ovf_o(w_ovf[1])
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic [7:0] s;
    logic       c;
    logic       o;
  } vec_t;

  vec_t vecs[6] = '{
    '{8'h3C, 8'h25, 1'b0, 8'h61, 1'b0, 1'b0},
    '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0},
    '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1},
    '{8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0},
    '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1},
    '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0}
  };

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Inputs are scrambled right after the accept edge; they must have no effect.
  task automatic start_op(input logic [7:0] av, input logic [7:0] bv, input logic sv);
    a = av; b = bv; sub = sv; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; a = ~av; b = ~bv; sub = ~sv;
  endtask

  task automatic wait_out(output int lat);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if ({in_ready, out_valid, s, cout, ovf} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: rdy=%b vld=%b s=%h c=%b o=%b, want rdy=1 vld=0 s=00 c=0 o=0",
               in_ready, out_valid, s, cout, ovf);
    end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if ({in_ready, out_valid, w_in_ready[0], w_in_ready[1], w_out_valid[0], w_out_valid[1]}
        !== 6'b101100) begin
      errors++;
      $display("FAIL reset_release: rdy=%b vld=%b wrdy=%b%b wvld=%b%b, want 1 0 11 00",
               in_ready, out_valid, w_in_ready[0], w_in_ready[1], w_out_valid[0], w_out_valid[1]);
    end
  endtask

  task automatic test_add_sub();
    int lat;
    foreach (vecs[i]) begin
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL vec%0d_in_ready: got %b want 1", i, in_ready);
      end
      start_op(vecs[i].a, vecs[i].b, vecs[i].sub);
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL vec%0d_busy: in_ready=%b want 0", i, in_ready);
      end
      wait_out(lat);
      checks++;
      if (lat != 4) begin
        errors++;
        $display("FAIL vec%0d_latency: got %0d want 4", i, lat);
      end
      checks++;
      if ({s, cout, ovf} !== {vecs[i].s, vecs[i].c, vecs[i].o}) begin
        errors++;
        $display("FAIL vec%0d_result: s=%h c=%b o=%b want s=%h c=%b o=%b",
                 i, s, cout, ovf, vecs[i].s, vecs[i].c, vecs[i].o);
      end
      handshake();
      checks++;
      if ({out_valid, in_ready, s} !== {1'b0, 1'b1, vecs[i].s}) begin
        errors++;
        $display("FAIL vec%0d_after_hs: vld=%b rdy=%b s=%h want vld=0 rdy=1 s=%h",
                 i, out_valid, in_ready, s, vecs[i].s);
      end
    end
  endtask

  task automatic test_hold();
    int lat;
    int bad = 0;
    int spurious = 0;
    start_op(8'h55, 8'h0F, 1'b0);
    wait_out(lat);
    checks++;
    if (lat != 4 || {s, cout, ovf} !== {8'h64, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL hold_first: lat=%0d s=%h c=%b o=%b want lat=4 s=64 c=0 o=0",
               lat, s, cout, ovf);
    end
    for (int i = 0; i < 6; i++) begin
      if (i == 2) begin
        a = 8'hAA; b = 8'hAA; sub = 1'b1; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if ({out_valid, in_ready, s, cout, ovf} !== {1'b1, 1'b0, 8'h64, 1'b0, 1'b0}) bad++;
    end
    in_valid = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL hold_stable: %0d unstable cycles, want 0", bad);
    end
    handshake();
    checks++;
    if ({out_valid, in_ready, s} !== {1'b0, 1'b1, 8'h64}) begin
      errors++;
      $display("FAIL hold_release: vld=%b rdy=%b s=%h want vld=0 rdy=1 s=64",
               out_valid, in_ready, s);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid || !in_ready) spurious++;
    end
    checks++;
    if (spurious != 0) begin
      errors++;
      $display("FAIL hold_ignored_input: %0d busy cycles, want 0", spurious);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    int seen = 0;
    start_op(8'h3C, 8'h25, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if ({in_ready, out_valid, s, cout, ovf} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL midrun_reset: rdy=%b vld=%b s=%h c=%b o=%b want 1 0 00 0 0",
               in_ready, out_valid, s, cout, ovf);
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL midrun_no_pulse: out_valid seen %0d cycles, want 0", seen);
    end
    start_op(8'h01, 8'h02, 1'b0);
    wait_out(lat);
    checks++;
    if (lat != 4 || {s, cout, ovf} !== {8'h03, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL midrun_next_op: lat=%0d s=%h c=%b o=%b want lat=4 s=03 c=0 o=0",
               lat, s, cout, ovf);
    end
    handshake();
  endtask

  task automatic test_back_to_back(input int idx, input int lat_exp, input int nops);
    logic [15:0] av, bv, bp, es;
    logic        sv, ec, eo, r;
    logic [16:0] full;
    int          lat;
    for (int n = 0; n < nops; n++) begin
      checks++;
      if (w_in_ready[idx] !== 1'b1) begin
        errors++;
        $display("FAIL w%0d_op%0d_in_ready: got %b want 1", idx, n, w_in_ready[idx]);
      end
      av = 16'($urandom);
      bv = 16'($urandom);
      sv = 1'($urandom_range(0, 1));
      bp = sv ? ~bv : bv;
      full = {1'b0, av} + {1'b0, bp} + {16'h0, sv};
      es = full[15:0];
      ec = full[16];
      eo = (av[15] == bp[15]) && (es[15] != av[15]);
      w_a[idx] = av; w_b[idx] = bv; w_sub[idx] = sv; w_in_valid[idx] = 1'b1;
      tick();
      w_in_valid[idx] = 1'b0; w_a[idx] = ~av; w_b[idx] = ~bv; w_sub[idx] = ~sv;
      lat = -1;
      for (int i = 1; i <= 40; i++) begin
        tick();
        if (w_out_valid[idx]) begin
          lat = i;
          break;
        end
      end
      checks++;
      if (lat != lat_exp) begin
        errors++;
        $display("FAIL w%0d_op%0d_latency: got %0d want %0d", idx, n, lat, lat_exp);
      end
      checks++;
      if ({w_s[idx], w_cout[idx], w_ovf[idx]} !== {es, ec, eo}) begin
        errors++;
        $display("FAIL w%0d_op%0d_result: a=%h b=%h sub=%b s=%h c=%b o=%b want s=%h c=%b o=%b",
                 idx, n, av, bv, sv, w_s[idx], w_cout[idx], w_ovf[idx], es, ec, eo);
      end
      if (lat < 0) break;
      do begin
        r = 1'($urandom_range(0, 1));
        w_out_ready[idx] = r;
        tick();
      end while (!r);
      w_out_ready[idx] = 1'b0;
    end
  endtask

  initial begin
    in_valid = 1'b0; out_ready = 1'b0; sub = 1'b0; a = '0; b = '0;
    for (int i = 0; i < 2; i++) begin
      w_in_valid[i] = 1'b0; w_out_ready[i] = 1'b0; w_sub[i] = 1'b0;
      w_a[i] = '0; w_b[i] = '0;
    end
    tick();
    test_reset();
    test_add_sub();
    test_hold();
    test_reset_mid_run();
    test_back_to_back(0, 1, 1000);
    test_back_to_back(1, 16, 1000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
